// File: rtl/ql_alu_pkg.sv
// Shared sizing helpers and per-stage control record for the segmented add/subtract pipeline.
// Optional macro QL_ALU_FLAGS_EN adds the unsigned-borrow tracking bit to the stage record.
package ql_alu_pkg;

  function automatic int ql_alu_segs(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  // Elaboration-time sanity check: WIDTH must split evenly into SEG_W-bit segments.
  function automatic bit ql_alu_cfg_ok(input int width, input int seg_w, input int sgn);
    return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0) && (sgn == 0 || sgn == 1);
  endfunction

  typedef struct packed {
    logic valid;
`ifdef QL_ALU_FLAGS_EN
    logic bi;
`endif
  } stage_t;

endpackage

// File: rtl/ql_seg_alu_if.sv
// Valid/ready operand and result bundle for ql_seg_alu.
// Optional macro QL_ALU_FLAGS_EN adds the ovf and zero result flags.
interface ql_seg_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             bi;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] x;
  logic             co;
`ifdef QL_ALU_FLAGS_EN
  logic             ovf;
  logic             zero;
`endif

  modport master (
`ifdef QL_ALU_FLAGS_EN
    input  ovf, zero,
`endif
    output in_valid, a, b, ci, bi, out_ready,
    input  in_ready, out_valid, y, x, co
  );

  modport slave (
`ifdef QL_ALU_FLAGS_EN
    output ovf, zero,
`endif
    input  in_valid, a, b, ci, bi, out_ready,
    output in_ready, out_valid, y, x, co
  );
endinterface

// File: rtl/ql_alu_seg.sv
// One SEG_W-bit ripple full-adder segment with registered sum and carry-out.
// Registers advance only when en is high.
module ql_alu_seg #(
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] sum,
  output logic             co
);
  logic [SEG_W-1:0] sum_d;
  logic             co_d;

  always_comb begin
    logic c;
    c     = ci;
    sum_d = '0;
    for (int unsigned i = 0; i < SEG_W; i++) begin
      sum_d[i] = a[i] ^ b[i] ^ c;
      c        = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co_d = c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      co  <= 1'b0;
    end else if (en) begin
      sum <= sum_d;
      co  <= co_d;
    end
  end
endmodule

// File: rtl/ql_seg_alu.sv
// Segment-pipelined add/subtract: SEGS registered carry-chain segments with operand skew and sum deskew.
// Optional macro QL_ALU_FLAGS_EN adds the ovf/zero flags.
module ql_seg_alu
  import ql_alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SEG_W  = 8,
  parameter int SIGNED = 0
) (
  input logic          clk,
  input logic          rst_n,
  ql_seg_alu_if.slave  bus
);
  localparam int SEGS = ql_alu_segs(WIDTH, SEG_W);

  if (!ql_alu_cfg_ok(WIDTH, SEG_W, SIGNED)) begin : g_cfg_err
    $error("ql_seg_alu: WIDTH must be a positive multiple of SEG_W and SIGNED must be 0 or 1");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] y_w;
  logic [SEGS-1:0]  carry_q;
  logic [SEG_W-1:0] sum_q  [SEGS];
  logic [WIDTH-1:0] x_pipe [SEGS];
  stage_t           ctl    [SEGS];

  assign en           = !ctl[SEGS-1].valid || bus.out_ready;
  assign bus.in_ready = en && rst_n;
  assign b_eff        = bus.bi ? ~bus.b : bus.b;

  for (genvar k = 0; k < SEGS; k++) begin : g_stage
    localparam int unsigned DEPTH = k;
    localparam int unsigned DLY   = SEGS - 1 - k;

    logic [SEG_W-1:0] op_a;
    logic [SEG_W-1:0] op_b;
    logic             cin;

    if (k == 0) begin : g_head
      assign op_a = bus.a[SEG_W-1:0];
      assign op_b = b_eff[SEG_W-1:0];
      assign cin  = bus.ci;
    end else begin : g_skew
      logic [SEG_W-1:0] sk_a [DEPTH];
      logic [SEG_W-1:0] sk_b [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned j = 0; j < DEPTH; j++) begin
            sk_a[j] <= '0;
            sk_b[j] <= '0;
          end
        end else if (en) begin
          sk_a[0] <= bus.a[k*SEG_W +: SEG_W];
          sk_b[0] <= b_eff[k*SEG_W +: SEG_W];
          for (int unsigned j = 1; j < DEPTH; j++) begin
            sk_a[j] <= sk_a[j-1];
            sk_b[j] <= sk_b[j-1];
          end
        end
      end

      assign op_a = sk_a[k-1];
      assign op_b = sk_b[k-1];
      assign cin  = carry_q[k-1];
    end

    ql_alu_seg #(.SEG_W(SEG_W)) u_seg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .a     (op_a),
      .b     (op_b),
      .ci    (cin),
      .sum   (sum_q[k]),
      .co    (carry_q[k])
    );

    if (DLY == 0) begin : g_tail
      assign y_w[k*SEG_W +: SEG_W] = sum_q[k];
    end else begin : g_deskew
      logic [SEG_W-1:0] ds [DLY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned j = 0; j < DLY; j++) ds[j] <= '0;
        end else if (en) begin
          ds[0] <= sum_q[k];
          for (int unsigned j = 1; j < DLY; j++) ds[j] <= ds[j-1];
        end
      end

      assign y_w[k*SEG_W +: SEG_W] = ds[DLY-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SEGS; i++) begin
        x_pipe[i] <= '0;
        ctl[i]    <= '0;
      end
    end else if (en) begin
      x_pipe[0]    <= bus.a ^ b_eff;
      ctl[0].valid <= bus.in_valid;
`ifdef QL_ALU_FLAGS_EN
      ctl[0].bi    <= bus.bi;
`endif
      for (int unsigned i = 1; i < SEGS; i++) begin
        x_pipe[i] <= x_pipe[i-1];
        ctl[i]    <= ctl[i-1];
      end
    end
  end

  assign bus.out_valid = ctl[SEGS-1].valid;
  assign bus.y         = y_w;
  assign bus.x         = x_pipe[SEGS-1];
  assign bus.co        = carry_q[SEGS-1];

`ifdef QL_ALU_FLAGS_EN
  // Carry into the MSB equals y^x at the MSB, so signed overflow needs no extra register.
  assign bus.ovf  = (SIGNED != 0) ? (y_w[WIDTH-1] ^ x_pipe[SEGS-1][WIDTH-1] ^ carry_q[SEGS-1])
                                  : (carry_q[SEGS-1] ^ ctl[SEGS-1].bi);
  assign bus.zero = ctl[SEGS-1].valid && (y_w == '0);
`endif
endmodule

// File: tb/tb_ql_seg_alu.sv
// Self-checking bench for ql_seg_alu: arithmetic reference model with in-order scoreboard plus directed vectors.
// Flag checks are compiled in when QL_ALU_FLAGS_EN is defined.
module tb_ql_seg_alu;
  localparam int WIDTH = 32;
  localparam int SEG_W = 8;
  localparam int SEGS  = WIDTH / SEG_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ql_seg_alu_if #(.WIDTH(WIDTH)) bus ();

  ql_seg_alu #(.WIDTH(WIDTH), .SEG_W(SEG_W), .SIGNED(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] x;
    logic             co;
    logic             ovf;
    logic             zero;
    int               stamp;
  } exp_t;

  exp_t exp_q[$];
  int   en_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ci, input logic bi);
    exp_t             e;
    logic [WIDTH-1:0] bp;
    logic [WIDTH:0]   s;
    bp     = bi ? ~b : b;
    s      = {1'b0, a} + {1'b0, bp} + {{WIDTH{1'b0}}, ci};
    e.y    = s[WIDTH-1:0];
    e.co   = s[WIDTH];
    e.x    = a ^ bp;
    e.zero = (e.y == 0);
    e.ovf  = (a[WIDTH-1] == bp[WIDTH-1]) && (e.y[WIDTH-1] != a[WIDTH-1]);
    e.stamp = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard bookkeeping on the active edge (pre-update values).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      exp_t e;
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (bus.in_valid && bus.in_ready) begin
        e       = model(bus.a, bus.b, bus.ci, bus.bi);
        e.stamp = en_cnt;
        exp_q.push_back(e);
      end
      if (!bus.out_valid || bus.out_ready) en_cnt++;
    end
  end

  // Compare process: every cycle a result is presented.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 64'd1, 64'd0);
      end else begin
        chk("mon_y", bus.y, exp_q[0].y);
        chk("mon_x", bus.x, exp_q[0].x);
        chk("mon_co", bus.co, exp_q[0].co);
        chk("mon_latency", 64'(en_cnt - exp_q[0].stamp), 64'(SEGS));
`ifdef QL_ALU_FLAGS_EN
        chk("mon_ovf", bus.ovf, exp_q[0].ovf);
        chk("mon_zero", bus.zero, exp_q[0].zero);
`endif
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic ci, input logic bi);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = a; bus.b = b; bus.ci = ci; bus.bi = bi;
      #1 ok = bus.in_ready;
      @(posedge clk);
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_single(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic ci, input logic bi, input logic [WIDTH-1:0] ey,
                            input logic [WIDTH-1:0] ex, input logic eco);
    int n;
    n = 0;
    send(a, b, ci, bi);
    while (n < 12) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      n++;
      if (bus.out_valid) break;
    end
    chk({name, "_latency"}, 64'(n), 64'(SEGS));
    chk({name, "_y"}, bus.y, ey);
    chk({name, "_x"}, bus.x, ex);
    chk({name, "_co"}, bus.co, eco);
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] snap_y, snap_x;
    logic             snap_co;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.bi = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 64'd0);
    chk("rst_y", bus.y, 64'd0);
    chk("rst_x", bus.x, 64'd0);
    chk("rst_co", bus.co, 64'd0);
    chk("rst_in_ready", bus.in_ready, 64'd0);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", bus.in_ready, 64'd1);

    run_single("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFE, 1'b1);
    run_single("sub_neg", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    run_single("sub_pos", 32'd7, 32'd5, 1'b1, 1'b1, 32'h2, 32'hFFFF_FFFD, 1'b1);
    run_single("seg_carry", 32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 32'h00FE_00FE, 1'b0);
    run_single("sovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFE, 1'b0);
`ifdef QL_ALU_FLAGS_EN
    chk("sovf_ovf", bus.ovf, 64'd1);
    chk("sovf_zero", bus.zero, 64'd0);
`endif
    run_single("eq_sub", 32'h1234, 32'h1234, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1);
`ifdef QL_ALU_FLAGS_EN
    chk("eq_sub_zero", bus.zero, 64'd1);
    chk("eq_sub_ovf", bus.ovf, 64'd0);
`endif
    drain();

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = $urandom; bus.b = $urandom;
      bus.ci = 1'($urandom_range(0, 1)); bus.bi = 1'($urandom_range(0, 1));
      #1;
      if (i >= SEGS) chk("stream_out_valid", bus.out_valid, 64'd1);
      chk("stream_in_ready", bus.in_ready, 64'd1);
      @(posedge clk);
    end
    @(negedge clk) bus.in_valid = 1'b0;
    drain();

    for (int i = 0; i < 6; i++) send(32'h100 * (i + 1), 32'(i + 3), 1'b0, 1'b0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.a = 32'hABCD; bus.b = 32'h1111; bus.ci = 1'b0; bus.bi = 1'b0;
    #1;
    snap_y = bus.y; snap_x = bus.x; snap_co = bus.co;
    chk("bp_out_valid", bus.out_valid, 64'd1);
    for (int c = 0; c < 3; c++) begin
      chk("bp_in_ready", bus.in_ready, 64'd0);
      @(negedge clk);
      #1;
      chk("bp_y_hold", bus.y, snap_y);
      chk("bp_x_hold", bus.x, snap_x);
      chk("bp_co_hold", bus.co, snap_co);
      chk("bp_valid_hold", bus.out_valid, 64'd1);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(32'h5000 + 32'(i), 32'h7, 1'b1, 1'b1);
    @(negedge clk) bus.in_valid = 1'b0;
    drain();

    for (int i = 0; i < 5; i++) send(32'h0101_0101 * (i + 1), 32'h1, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 64'd0);
    chk("arst_y", bus.y, 64'd0);
    chk("arst_x", bus.x, 64'd0);
    chk("arst_co", bus.co, 64'd0);
    chk("arst_in_ready", bus.in_ready, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("arst_release_in_ready", bus.in_ready, 64'd1);
    run_single("after_rst", 32'h10, 32'h20, 1'b0, 1'b0, 32'h30, 32'h30, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
